byte_packer: RTL and testbench



---
 rtl/byte_packer.sv | 112 +++++++++++
 tb/tb_byte_packer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_packer.sv
// Byte-to-word packer: BYTES consecutive bytes form one word, first byte in the MSB.
// Optional BYTE_PACKER_FLUSH_EN adds a flush input and an out_count output for partial words.
module byte_packer #(
    parameter int BYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [7:0]           in_byte,
    output logic                 in_ready,
    input  logic                 clr,
    output logic                 out_valid,
    output logic [8*BYTES-1:0]   out_word,
    input  logic                 out_ready,
    output logic                 busy
`ifdef BYTE_PACKER_FLUSH_EN
    ,
    input  logic                 flush,
    output logic [$clog2(BYTES+1)-1:0] out_count
`endif
);

    localparam int W   = 8 * BYTES;
    localparam int CW  = $clog2(BYTES);
    localparam int OCW = $clog2(BYTES + 1);
    localparam logic [CW-1:0] LAST = CW'(BYTES - 1);

    logic [W-1:0]   acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   out_word_q, out_word_d;
    logic           out_valid_q, out_valid_d;
    logic [OCW-1:0] out_count_q, out_count_d;

    logic in_fire;
    logic out_fire;
    logic slot_free;
    logic flush_fire;

    assign out_fire  = out_valid_q && out_ready;
    assign slot_free = !out_valid_q || out_ready;

`ifdef BYTE_PACKER_FLUSH_EN
    assign in_ready   = ((cnt_q != LAST) || slot_free) && !flush;
    assign flush_fire = flush && (cnt_q != '0) && slot_free;
    assign out_count  = out_count_q;
`else
    assign in_ready   = (cnt_q != LAST) || slot_free;
    assign flush_fire = 1'b0;
`endif

    assign in_fire   = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_word  = out_word_q;
    assign busy      = (cnt_q != '0);

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_word_d  = out_word_q;
        out_valid_d = out_valid_q && !out_fire;
        out_count_d = out_count_q;

        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (flush_fire) begin
            // Unwritten low bytes of acc are already zero, giving the padding for free.
            out_word_d  = acc_q;
            out_valid_d = 1'b1;
            out_count_d = OCW'(cnt_q);
            acc_d       = '0;
            cnt_d       = '0;
        end else if (in_fire) begin
            if (cnt_q == LAST) begin
                out_word_d  = acc_q | {{(W-8){1'b0}}, in_byte};
                out_valid_d = 1'b1;
                out_count_d = OCW'(BYTES);
                acc_d       = '0;
                cnt_d       = '0;
            end else begin
                for (int i = 0; i < BYTES - 1; i++) begin
                    if (cnt_q == CW'(i)) begin
                        acc_d[W-1-8*i -: 8] = in_byte;
                    end
                end
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_word_q  <= '0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_word_q  <= out_word_d;
            out_valid_q <= out_valid_d;
            out_count_q <= out_count_d;
        end
    end

`ifndef BYTE_PACKER_FLUSH_EN
    logic unused_count;
    assign unused_count = ^out_count_q;
`endif

endmodule

// File: tb/tb_byte_packer.sv
// Bench for byte_packer: directed steps plus random traffic checked against a queue-based model.
module tb_byte_packer;

    localparam int BYTES = 4;
    localparam int W     = 8 * BYTES;
    localparam int OCW   = $clog2(BYTES + 1);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [7:0]   in_byte;
    logic         in_ready;
    logic         clr;
    logic         out_valid;
    logic [W-1:0] out_word;
    logic         out_ready;
    logic         busy;
`ifdef BYTE_PACKER_FLUSH_EN
    logic           flush;
    logic [OCW-1:0] out_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0]   part[$];
    logic [W-1:0] exp_w[$];
    int           exp_c[$];

    always #5 clk = ~clk;

    byte_packer #(.BYTES(BYTES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .clr       (clr),
        .out_valid (out_valid),
        .out_word  (out_word),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef BYTE_PACKER_FLUSH_EN
        ,
        .flush     (flush),
        .out_count (out_count)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_assert++;
        assert (obs === want)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Bytes held so far, left-justified into a word with zero padding below.
    function automatic logic [W-1:0] pack_part();
        logic [W-1:0] w = '0;
        foreach (part[i]) w = (w << 8) | W'(part[i]);
        return w << (8 * (BYTES - part.size()));
    endfunction

    // Called just after a falling edge with inputs set; checks, updates the model, advances one clock.
    task automatic cycle(output bit acc);
        bit exp_rdy;
        bit f_ev;
        #1;
        exp_rdy = (part.size() != BYTES - 1) || (exp_w.size() == 0) || out_ready;
        f_ev = 1'b0;
`ifdef BYTE_PACKER_FLUSH_EN
        exp_rdy = exp_rdy && !flush;
        f_ev = flush && (part.size() > 0) && ((exp_w.size() == 0) || out_ready);
`endif
        check("out_valid", 64'(out_valid), 64'(exp_w.size() != 0));
        if (exp_w.size() != 0) begin
            check("out_word", 64'(out_word), 64'(exp_w[0]));
`ifdef BYTE_PACKER_FLUSH_EN
            check("out_count", 64'(out_count), 64'(exp_c[0]));
`endif
        end
        check("busy", 64'(busy), 64'(part.size() != 0));
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        acc = in_valid && exp_rdy;

        if ((exp_w.size() != 0) && out_ready) begin
            void'(exp_w.pop_front());
            void'(exp_c.pop_front());
        end
        if (clr) begin
            part.delete();
        end else if (f_ev) begin
            exp_w.push_back(pack_part());
            exp_c.push_back(part.size());
            part.delete();
        end else if (acc) begin
            part.push_back(in_byte);
            if (part.size() == BYTES) begin
                exp_w.push_back(pack_part());
                exp_c.push_back(BYTES);
                part.delete();
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, output int tries);
        bit acc;
        in_valid = 1'b1;
        in_byte  = b;
        tries    = 0;
        acc      = 1'b0;
        while (!acc && tries < 16) begin
            cycle(acc);
            tries++;
        end
        if (!acc) check("send_timeout", 64'(tries), 64'(0));
    endtask

    initial begin
        bit acc;
        int tries;
        int stalls;
        logic [7:0] seq[$];

        rst_n = 1'b0; in_valid = 1'b0; in_byte = '0; clr = 1'b0; out_ready = 1'b0;
`ifdef BYTE_PACKER_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_word", 64'(out_word), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        rst_n = 1'b1;

        // Basic word
        out_ready = 1'b1;
        seq = '{8'h12, 8'h34, 8'h56, 8'h78};
        foreach (seq[i]) send_byte(seq[i], tries);
        in_valid = 1'b0;
        #1 check("t1_word", 64'(out_word), 64'h12345678);
        check("t1_valid", 64'(out_valid), 64'(1));
        cycle(acc);
        cycle(acc);

        // Backpressure: final byte of second word stalls
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) send_byte(8'hA0 + 8'(i), tries);
        in_valid = 1'b1;
        in_byte  = 8'hA7;
        repeat (3) begin
            #1 check("t2_stall", 64'(in_ready), 64'(0));
            check("t2_hold", 64'(out_word), 64'hA0A1A2A3);
            cycle(acc);
        end
        out_ready = 1'b1;
        cycle(acc);
        in_valid = 1'b0;
        #1 check("t2_second", 64'(out_word), 64'hA4A5A6A7);
        cycle(acc);
        cycle(acc);

        // Continuous stream without stalls
        stalls = 0;
        for (int i = 0; i < 40; i++) begin
            send_byte(8'($urandom), tries);
            if (tries != 1) stalls++;
        end
        in_valid = 1'b0;
        check("t3_stalls", 64'(stalls), 64'(0));
        cycle(acc);
        cycle(acc);

        // clr discards partial word and the same-cycle byte
        send_byte(8'h11, tries);
        send_byte(8'h22, tries);
        in_byte = 8'h33;
        clr = 1'b1;
        cycle(acc);
        clr = 1'b0;
        seq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        foreach (seq[i]) send_byte(seq[i], tries);
        in_valid = 1'b0;
        #1 check("t4_word", 64'(out_word), 64'hDEADBEEF);
        cycle(acc);
        cycle(acc);

        // Async reset mid-word with a held word
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) send_byte(8'hC0 + 8'(i), tries);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("t5_rst_valid", 64'(out_valid), 64'(0));
        check("t5_rst_busy", 64'(busy), 64'(0));
        part.delete();
        exp_w.delete();
        exp_c.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        seq = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        foreach (seq[i]) send_byte(seq[i], tries);
        in_valid = 1'b0;
        #1 check("t5_word", 64'(out_word), 64'hCAFEF00D);
        cycle(acc);
        cycle(acc);

`ifdef BYTE_PACKER_FLUSH_EN
        send_byte(8'hAB, tries);
        send_byte(8'hCD, tries);
        in_valid = 1'b0;
        flush = 1'b1;
        cycle(acc);
        flush = 1'b0;
        #1 check("t6_word", 64'(out_word), 64'hABCD0000);
        check("t6_count", 64'(out_count), 64'(2));
        cycle(acc);
        flush = 1'b1;
        cycle(acc);
        flush = 1'b0;
        #1 check("t6_idle_flush", 64'(out_valid), 64'(0));
        cycle(acc);
`endif

        // Random traffic
        repeat (500) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_byte   = 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            clr       = ($urandom_range(0, 24) == 0);
`ifdef BYTE_PACKER_FLUSH_EN
            flush     = ($urandom_range(0, 14) == 0);
`endif
            cycle(acc);
        end
        in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
`ifdef BYTE_PACKER_FLUSH_EN
        flush = 1'b0;
`endif
        repeat (4) cycle(acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
